// File: rtl/hpc3_rand_feeder.sv
// Fresh-randomness source for HPC3 masked multipliers: a bank of leap-forward
// 32-bit LFSRs, seeded word by word, advanced only on consumer draws.
module hpc3_rand_feeder #(
  parameter int NUM_SHARES    = 2,
  parameter int BIT_WIDTH     = 1,
  parameter int NUM_MULS      = 16,
  parameter int RESEED_PERIOD = 1024
) (
  input  logic                                        in_clock,
  input  logic                                        in_reset,
  input  logic [31:0]                                 in_seed,
  input  logic                                        in_seed_valid,
  output logic                                        out_seed_ready,
  input  logic                                        in_reseed,
  input  logic                                        in_enable,
  output logic                                        out_valid,
  output logic [NUM_MULS*(NUM_SHARES*(NUM_SHARES-1)/2)*BIT_WIDTH-1:0] out_r,
  output logic [NUM_MULS*(NUM_SHARES*(NUM_SHARES-1)/2)*BIT_WIDTH-1:0] out_p,
  output logic                                        out_reseed_req
);

  // Pairwise share products per multiplier, as counted by the AES package.
  function automatic int num_quad(input int n);
    return n * (n - 1) / 2;
  endfunction

  localparam int NUM_QUAD  = num_quad(NUM_SHARES);
  localparam int OUT_W     = NUM_MULS * NUM_QUAD * BIT_WIDTH;
  localparam int RAND_BITS = 2 * OUT_W;
  localparam int NUM_LFSR  = (RAND_BITS + 31) / 32;
  localparam int IDX_W     = (NUM_LFSR > 1) ? $clog2(NUM_LFSR) : 1;
  localparam int CNT_W     = $clog2(RESEED_PERIOD + 1);

  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_LFSR - 1);
  localparam logic [CNT_W-1:0] PERIOD_CNT = CNT_W'(RESEED_PERIOD);

  typedef enum logic [1:0] {
    UNSEEDED,
    SEED,
    RUN
  } state_t;

  state_t           state, state_next;
  logic [31:0]      lfsr_q [NUM_LFSR];
  logic [IDX_W-1:0] idx_q;
  logic [CNT_W-1:0] cnt_q;
  logic [32*NUM_LFSR-1:0] pool;
  logic             seed_fire;

  // Thirty-two single steps unrolled, so every draw yields a fully new word.
  function automatic logic [31:0] leap(input logic [31:0] s);
    logic [31:0] v;
    v = s;
    for (int i = 0; i < 32; i++) begin
      v = {v[30:0], v[31] ^ v[21] ^ v[1] ^ v[0]};
    end
    return v;
  endfunction

  assign seed_fire = in_seed_valid && out_seed_ready;

  always_ff @(posedge in_clock or negedge in_reset) begin
    if (!in_reset) state <= UNSEEDED;
    else           state <= state_next;
  end

  always_comb begin
    state_next     = state;
    out_seed_ready = 1'b0;
    out_valid      = 1'b0;
    case (state)
      UNSEEDED, SEED: begin
        out_seed_ready = 1'b1;
        if (seed_fire) state_next = (idx_q == LAST_IDX) ? RUN : SEED;
      end
      RUN: begin
        out_valid = 1'b1;
        if (in_reseed) state_next = SEED;
      end
      default: state_next = UNSEEDED;
    endcase
  end

  // A zero seed would lock the LFSR at zero forever, so it is loaded as 1.
  always_ff @(posedge in_clock or negedge in_reset) begin
    if (!in_reset) begin
      for (int k = 0; k < NUM_LFSR; k++) lfsr_q[k] <= 32'h0000_0001;
      idx_q <= '0;
      cnt_q <= '0;
    end else if (seed_fire) begin
      lfsr_q[idx_q] <= (in_seed == 32'h0) ? 32'h0000_0001 : in_seed;
      if (idx_q == LAST_IDX) begin
        idx_q <= '0;
        cnt_q <= '0;
      end else begin
        idx_q <= idx_q + 1'b1;
      end
    end else if (state == RUN) begin
      if (in_enable) begin
        for (int k = 0; k < NUM_LFSR; k++) lfsr_q[k] <= leap(lfsr_q[k]);
        if (cnt_q != PERIOD_CNT) cnt_q <= cnt_q + 1'b1;
      end
      if (in_reseed) begin
        idx_q <= '0;
        cnt_q <= '0;
      end
    end
  end

  always_comb begin
    pool = '0;
    for (int k = 0; k < NUM_LFSR; k++) pool[32*k +: 32] = lfsr_q[k];
  end

  assign out_r          = out_valid ? pool[OUT_W-1:0]       : '0;
  assign out_p          = out_valid ? pool[2*OUT_W-1:OUT_W] : '0;
  assign out_reseed_req = (state == RUN) && (cnt_q == PERIOD_CNT);

endmodule
